port_decode_reg: RTL and testbench
==================================

Name: port_decode_reg

Overview:
Parametrised, registered successor to the UART's PicoBlaze I/O address decoder. It decodes port_ID plus write/read strobes into one-hot, single-cycle write/read selects for NPORTS peripheral registers. It also registers the selected peripheral's read data onto in_port and flags bus errors. It sits between the PicoBlaze core and the UART TX/RX/baud/status register bank.

Parameters:
ADDR_W, 16, width of port_ID
SEL_BITS, 3, low address bits decoded; NPORTS = 2**SEL_BITS
WIN_BIT, 15, port_ID bit that must be 0 for an in-window access (WIN_BIT < ADDR_W)
DATA_W, 8, peripheral read-data width
EDGE_MODE, 1, 1 = one select pulse per strobe assertion; 0 = select follows the strobe every cycle

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
port_ID  in  ADDR_W  processor port address
write_strobe  in  1  processor write strobe
read_strobe  in  1  processor read strobe
rd_bus  in  NPORTS*DATA_W  packed peripheral read data; port k occupies bits [k*DATA_W +: DATA_W]
clr_err  in  1  synchronous clear of the sticky error flags
write  out  NPORTS  registered one-hot write select
read  out  NPORTS  registered one-hot read select
in_port  out  DATA_W  registered read data returned to the processor
oow_err  out  1  sticky: a strobe occurred with port_ID[WIN_BIT]=1
coll_err  out  1  sticky: write_strobe and read_strobe were high in the same cycle

Behaviour:
- Reset (reset_n=0, asynchronous): write=0, read=0, in_port=0, oow_err=0, coll_err=0. Edge-detect history is cleared to 0.
- hit = (port_ID[WIN_BIT]==0). idx = port_ID[SEL_BITS-1:0]. Upper bits other than WIN_BIT are ignored (aliasing).
- Strobe qualification:
  - EDGE_MODE=1: wq = write_strobe & ~write_strobe_d, where write_strobe_d is the strobe registered last cycle. rq is formed the same way from read_strobe.
  - EDGE_MODE=0: wq = write_strobe, rq = read_strobe.
- Latency 1: at clock edge N+1, write <= (wq&hit) ? onehot(idx) : 0 and read <= (rq&hit) ? onehot(idx) : 0, using the inputs sampled at edge N.
  - Each select is 0 or exactly one-hot. Every select is high for exactly one cycle per qualified strobe.
- in_port: on the edge where rq&hit, in_port <= rd_bus slice for idx. It holds that value until the next qualified in-window read. Out-of-window reads leave in_port unchanged.
- EDGE_MODE=1 with a strobe held high over several cycles: only the first cycle produces a pulse. A changing port_ID during the hold produces no further pulses. A strobe must drop for at least one cycle to re-arm.
- oow_err: set on any cycle where (write_strobe|read_strobe) & ~hit. This check uses the raw strobes, not the qualified ones.
- coll_err: set on any cycle where write_strobe & read_strobe. Both selects are still issued, and each is independently decoded from idx.
- clr_err=1 clears both flags on the next edge. If a set condition occurs in the same cycle, set wins.
- Reset asserted mid-pulse: the outputs drop immediately. After release, a strobe already high is treated as new in EDGE_MODE=1, because its history is 0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then idle -> write=0, read=0, in_port=0x00, both flags 0. Assert reset_n=0 while write=0x04 -> write=0x00 asynchronously, without waiting for a clock edge.
- EDGE_MODE=1: port_ID=0x0003, write_strobe high 1 cycle -> write=0x08 exactly one cycle later, for one cycle. Hold write_strobe 4 cycles -> one pulse only. EDGE_MODE=0, same 4-cycle hold -> four consecutive 0x08 cycles.
- rd_bus slot 5 = 0xA5, port_ID=0x0005, read_strobe 1 cycle -> read=0x20 and in_port=0xA5 on the next edge. Change slot 5 to 0x3C with no strobe -> in_port stays 0xA5.
- port_ID=0x8002 with write_strobe -> write stays 0x00 and oow_err=1. Pulse clr_err alone -> oow_err=0. Pulse clr_err together with another 0x8002 strobe -> oow_err stays 1.
- port_ID=0x0001 with both strobes in one cycle -> write=0x02, read=0x02, coll_err=1.
- Alias check: port_ID=0x7FF9 read -> read=0x02 (idx=1), no error.

Source files
------------

// File: rtl/port_decode_reg.sv
`default_nettype none
// ============================================================================
// Module      : port_decode_reg
// Description : Registered PicoBlaze I/O port decoder. Turns port_ID plus the
//               write/read strobes into one-hot, single-cycle write/read
//               selects for NPORTS peripheral registers, returns the selected
//               peripheral's read data on in_port and keeps sticky
//               out-of-window and strobe-collision error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module port_decode_reg #(
    parameter int ADDR_W    = 16,
    parameter int SEL_BITS  = 3,
    parameter int WIN_BIT   = 15,
    parameter int DATA_W    = 8,
    parameter int EDGE_MODE = 1,
    localparam int NPORTS   = 2 ** SEL_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        port_ID,
    input  logic                     write_strobe,
    input  logic                     read_strobe,
    input  logic [NPORTS*DATA_W-1:0] rd_bus,
    input  logic                     clr_err,
    output logic [NPORTS-1:0]        write,
    output logic [NPORTS-1:0]        read,
    output logic [DATA_W-1:0]        in_port,
    output logic                     oow_err,
    output logic                     coll_err
);

    localparam logic [NPORTS-1:0] c_ONE = {{(NPORTS-1){1'b0}}, 1'b1};

    logic                 w_hit;
    logic [SEL_BITS-1:0]  w_idx;
    logic [NPORTS-1:0]    w_onehot;
    logic                 w_wq;
    logic                 w_rq;
    logic                 w_oow_set;
    logic                 w_coll_set;
    logic [DATA_W-1:0]    w_rd_slice;

    logic [NPORTS-1:0]    r_write;
    logic [NPORTS-1:0]    r_read;
    logic [DATA_W-1:0]    r_in_port;
    logic                 r_oow_err;
    logic                 r_coll_err;

    // Address bits above the select field other than WIN_BIT alias by design.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, port_ID};

    assign w_hit      = ~port_ID[WIN_BIT];
    assign w_idx      = port_ID[SEL_BITS-1:0];
    assign w_onehot   = c_ONE << w_idx;
    assign w_rd_slice = rd_bus[w_idx*DATA_W +: DATA_W];

    // Error conditions look at the raw strobes, not the qualified ones.
    assign w_oow_set  = (write_strobe | read_strobe) & ~w_hit;
    assign w_coll_set = write_strobe & read_strobe;

    generate
        if (EDGE_MODE != 0) begin : g_edge_qual
            logic r_write_strobe_d;
            logic r_read_strobe_d;

            // Strobe history for rising-edge qualification; cleared by reset so
            // a strobe already high at release counts as new.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_write_strobe_d <= 1'b0;
                    r_read_strobe_d  <= 1'b0;
                end else begin
                    r_write_strobe_d <= write_strobe;
                    r_read_strobe_d  <= read_strobe;
                end
            end

            assign w_wq = write_strobe & ~r_write_strobe_d;
            assign w_rq = read_strobe  & ~r_read_strobe_d;
        end else begin : g_level_qual
            assign w_wq = write_strobe;
            assign w_rq = read_strobe;
        end
    endgenerate

    // One-cycle-latency select decode; selects are zero or exactly one-hot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write <= '0;
            r_read  <= '0;
        end else begin
            r_write <= (w_wq & w_hit) ? w_onehot : '0;
            r_read  <= (w_rq & w_hit) ? w_onehot : '0;
        end
    end

    // Capture read data only on a qualified in-window read; hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_port <= '0;
        end else if (w_rq & w_hit) begin
            r_in_port <= w_rd_slice;
        end
    end

    // Sticky error flags; a set condition wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_oow_err  <= 1'b0;
            r_coll_err <= 1'b0;
        end else begin
            if (w_oow_set) begin
                r_oow_err <= 1'b1;
            end else if (clr_err) begin
                r_oow_err <= 1'b0;
            end
            if (w_coll_set) begin
                r_coll_err <= 1'b1;
            end else if (clr_err) begin
                r_coll_err <= 1'b0;
            end
        end
    end

    assign write    = r_write;
    assign read     = r_read;
    assign in_port  = r_in_port;
    assign oow_err  = r_oow_err;
    assign coll_err = r_coll_err;

endmodule
`default_nettype wire

// File: tb/tb_port_decode_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_decode_reg
// Description : Self-checking bench for port_decode_reg. Runs an edge-mode and
//               a level-mode instance side by side on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_decode_reg;

    localparam int ADDR_W   = 16;
    localparam int SEL_BITS = 3;
    localparam int WIN_BIT  = 15;
    localparam int DATA_W   = 8;
    localparam int NPORTS   = 8;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [ADDR_W-1:0]        port_ID;
    logic                     write_strobe;
    logic                     read_strobe;
    logic [NPORTS*DATA_W-1:0] rd_bus;
    logic                     clr_err;

    logic [NPORTS-1:0] write_e, read_e, write_l, read_l;
    logic [DATA_W-1:0] in_port_e, in_port_l;
    logic              oow_e, coll_e, oow_l, coll_l;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int unsigned m_w_e, m_r_e, m_w_l, m_r_l, m_in_e, m_in_l;
    bit          m_oow, m_coll, m_prev_ws, m_prev_rs;

    always #5 clk = ~clk;

    port_decode_reg #(
        .ADDR_W(ADDR_W), .SEL_BITS(SEL_BITS), .WIN_BIT(WIN_BIT),
        .DATA_W(DATA_W), .EDGE_MODE(1)
    ) u_dut_edge (
        .clk(clk), .reset_n(reset_n), .port_ID(port_ID),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .rd_bus(rd_bus), .clr_err(clr_err),
        .write(write_e), .read(read_e), .in_port(in_port_e),
        .oow_err(oow_e), .coll_err(coll_e)
    );

    port_decode_reg #(
        .ADDR_W(ADDR_W), .SEL_BITS(SEL_BITS), .WIN_BIT(WIN_BIT),
        .DATA_W(DATA_W), .EDGE_MODE(0)
    ) u_dut_level (
        .clk(clk), .reset_n(reset_n), .port_ID(port_ID),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .rd_bus(rd_bus), .clr_err(clr_err),
        .write(write_l), .read(read_l), .in_port(in_port_l),
        .oow_err(oow_l), .coll_err(coll_l)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w_e = 0; m_r_e = 0; m_w_l = 0; m_r_l = 0; m_in_e = 0; m_in_l = 0;
        m_oow = 0; m_coll = 0; m_prev_ws = 0; m_prev_rs = 0;
    endtask

    // Advance one clock: predict from the current inputs, then compare both DUTs.
    task automatic cycle();
        bit          hit, wq, rq;
        int unsigned idx, onehot, slot;
        hit    = (port_ID[WIN_BIT] == 1'b0);
        idx    = port_ID % NPORTS;
        onehot = 1 << idx;
        slot   = int'((rd_bus >> (idx * DATA_W)) & 64'hFF);
        wq     = write_strobe && !m_prev_ws;
        rq     = read_strobe  && !m_prev_rs;
        m_w_e  = (wq && hit) ? onehot : 0;
        m_r_e  = (rq && hit) ? onehot : 0;
        m_w_l  = (write_strobe && hit) ? onehot : 0;
        m_r_l  = (read_strobe  && hit) ? onehot : 0;
        if (rq && hit)          m_in_e = slot;
        if (read_strobe && hit) m_in_l = slot;
        if ((write_strobe || read_strobe) && !hit) m_oow = 1;
        else if (clr_err)                          m_oow = 0;
        if (write_strobe && read_strobe) m_coll = 1;
        else if (clr_err)                m_coll = 0;
        m_prev_ws = write_strobe;
        m_prev_rs = read_strobe;
        @(posedge clk);
        #1;
        chk("edge_write", write_e,   m_w_e);
        chk("edge_read",  read_e,    m_r_e);
        chk("edge_in",    in_port_e, m_in_e);
        chk("edge_oow",   oow_e,     m_oow);
        chk("edge_coll",  coll_e,    m_coll);
        chk("lvl_write",  write_l,   m_w_l);
        chk("lvl_read",   read_l,    m_r_l);
        chk("lvl_in",     in_port_l, m_in_l);
        chk("lvl_oow",    oow_l,     m_oow);
        chk("lvl_coll",   coll_l,    m_coll);
    endtask

    typedef struct {
        logic        ws;
        logic        rs;
        logic        clr;
        logic [15:0] pid;
        logic [63:0] bus;
        logic [7:0]  ew;
        logic [7:0]  er;
        logic [7:0]  ein;
        logic        eoow;
        logic        ecoll;
    } vec_t;

    localparam logic [63:0] BUS_A = 64'h0000_A500_0000_1100;
    localparam logic [63:0] BUS_B = 64'h0000_3C00_0000_1100;

    vec_t tbl[19];

    initial begin
        // Directed sequence, expectations for the edge-mode instance
        tbl[0]  = '{0, 0, 0, 16'h0000, BUS_A, 8'h00, 8'h00, 8'h00, 0, 0};
        tbl[1]  = '{1, 0, 0, 16'h0003, BUS_A, 8'h08, 8'h00, 8'h00, 0, 0};
        tbl[2]  = '{0, 0, 0, 16'h0003, BUS_A, 8'h00, 8'h00, 8'h00, 0, 0};
        tbl[3]  = '{1, 0, 0, 16'h0003, BUS_A, 8'h08, 8'h00, 8'h00, 0, 0};
        tbl[4]  = '{1, 0, 0, 16'h0004, BUS_A, 8'h00, 8'h00, 8'h00, 0, 0};
        tbl[5]  = '{1, 0, 0, 16'h0003, BUS_A, 8'h00, 8'h00, 8'h00, 0, 0};
        tbl[6]  = '{1, 0, 0, 16'h0003, BUS_A, 8'h00, 8'h00, 8'h00, 0, 0};
        tbl[7]  = '{0, 0, 0, 16'h0003, BUS_A, 8'h00, 8'h00, 8'h00, 0, 0};
        tbl[8]  = '{0, 1, 0, 16'h0005, BUS_A, 8'h00, 8'h20, 8'hA5, 0, 0};
        tbl[9]  = '{0, 0, 0, 16'h0005, BUS_B, 8'h00, 8'h00, 8'hA5, 0, 0};
        tbl[10] = '{1, 0, 0, 16'h8002, BUS_B, 8'h00, 8'h00, 8'hA5, 1, 0};
        tbl[11] = '{0, 0, 0, 16'h8002, BUS_B, 8'h00, 8'h00, 8'hA5, 1, 0};
        tbl[12] = '{0, 0, 1, 16'h8002, BUS_B, 8'h00, 8'h00, 8'hA5, 0, 0};
        tbl[13] = '{1, 0, 1, 16'h8002, BUS_B, 8'h00, 8'h00, 8'hA5, 1, 0};
        tbl[14] = '{0, 0, 1, 16'h8002, BUS_B, 8'h00, 8'h00, 8'hA5, 0, 0};
        tbl[15] = '{1, 1, 0, 16'h0001, BUS_B, 8'h02, 8'h02, 8'h11, 0, 1};
        tbl[16] = '{0, 0, 1, 16'h0001, BUS_B, 8'h00, 8'h00, 8'h11, 0, 0};
        tbl[17] = '{0, 1, 0, 16'h7FF9, BUS_B, 8'h00, 8'h02, 8'h11, 0, 0};
        tbl[18] = '{0, 0, 0, 16'h0000, BUS_B, 8'h00, 8'h00, 8'h11, 0, 0};

        reset_n = 1'b0; port_ID = '0; write_strobe = 0; read_strobe = 0;
        rd_bus = '0; clr_err = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write", write_e, 0);
        chk("rst_read",  read_e,  0);
        chk("rst_in",    in_port_e, 0);
        chk("rst_oow",   oow_e,   0);
        chk("rst_coll",  coll_e,  0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            write_strobe = tbl[i].ws;
            read_strobe  = tbl[i].rs;
            clr_err      = tbl[i].clr;
            port_ID      = tbl[i].pid;
            rd_bus       = tbl[i].bus;
            cycle();
            chk($sformatf("tbl%0d_write", i), write_e,   tbl[i].ew);
            chk($sformatf("tbl%0d_read", i),  read_e,    tbl[i].er);
            chk($sformatf("tbl%0d_in", i),    in_port_e, tbl[i].ein);
            chk($sformatf("tbl%0d_oow", i),   oow_e,     tbl[i].eoow);
            chk($sformatf("tbl%0d_coll", i),  coll_e,    tbl[i].ecoll);
        end

        // Level mode: a 4-cycle write hold gives four consecutive selects
        port_ID = 16'h0003; write_strobe = 1; read_strobe = 0; clr_err = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("lvl_hold%0d", i), write_l, 8'h08);
        end
        write_strobe = 0;
        cycle();

        // Asynchronous reset while a select is high, then strobe held through release
        port_ID = 16'h0002; write_strobe = 1;
        cycle();
        chk("pre_rst_write", write_e, 8'h04);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_write_e", write_e, 8'h00);
        chk("async_rst_write_l", write_l, 8'h00);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        chk("rearm_after_rst", write_e, 8'h04);
        write_strobe = 0;
        cycle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            write_strobe = ($urandom_range(0, 2) == 0);
            read_strobe  = ($urandom_range(0, 2) == 0);
            clr_err      = ($urandom_range(0, 5) == 0);
            port_ID      = 16'($urandom);
            if ($urandom_range(0, 3) != 0) port_ID[WIN_BIT] = 1'b0;
            rd_bus       = {$urandom, $urandom};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
